// File: rtl/xillybus_lite_gpio_irq_if.sv
// Xillybus Lite user register bus: single-cycle write/read strobes, registered read data, level IRQ.
// The master drives address, strobes and write data. The slave returns read data and the interrupt.
interface xillybus_lite_gpio_irq_if;
  logic [31:0] user_addr;
  logic        user_wren;
  logic [3:0]  user_wstrb;
  logic [31:0] user_wr_data;
  logic        user_rden;
  logic [31:0] user_rd_data;
  logic        user_irq;

  modport master (
    output user_addr, user_wren, user_wstrb, user_wr_data, user_rden,
    input  user_rd_data, user_irq
  );

  modport slave (
    input  user_addr, user_wren, user_wstrb, user_wr_data, user_rden,
    output user_rd_data, user_irq
  );
endinterface

// File: rtl/xillybus_lite_gpio_irq.sv
// GPIO with per-pin direction/output, synchronised inputs, edge capture (sticky STAT) and a maskable level IRQ.
// Read data arrives 1 cycle after user_rden and writes apply on the strobe edge; there is no backpressure.
module xillybus_lite_gpio_irq #(
  parameter int GPIO_WIDTH  = 56,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_BITS   = 8
) (
  input  logic                   bus_clk,
  input  logic                   bus_rst_n,
  xillybus_lite_gpio_irq_if.slave bus,
  input  logic [GPIO_WIDTH-1:0]  gpio_i,
  output logic [GPIO_WIDTH-1:0]  gpio_o,
  output logic [GPIO_WIDTH-1:0]  gpio_t
);
  localparam int NB = (GPIO_WIDTH + 31) / 32;
  localparam int PW = NB * 32;
  localparam int CW = $clog2(SYNC_STAGES + 2);
  localparam int HB = ADDR_BITS - 5;
  localparam logic [CW-1:0] PRIME_DONE = CW'(SYNC_STAGES + 1);
  localparam logic [15:0]   GPIO_W16   = 16'(GPIO_WIDTH);

  function automatic logic [PW-1:0] pin_mask();
    logic [PW-1:0] m;
    m = '0;
    for (int i = 0; i < GPIO_WIDTH; i++) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [PW-1:0] PMASK = pin_mask();

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [31:0] be_v);
    return (old_v & ~be_v) | (new_v & be_v);
  endfunction

  logic [PW-1:0] out_q, out_d, dir_q, dir_d, mask_q, mask_d;
  logic [PW-1:0] rise_q, rise_d, fall_q, fall_d, stat_q, stat_d;
  logic          gie_q, gie_d;
  logic [31:0]   rd_q, rd_d;
  logic          irq_q, irq_d;
  logic [CW-1:0] prime_q, prime_d;
  logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [GPIO_WIDTH-1:0] prev_q;

  logic [ADDR_BITS-1:0] off;
  logic [HB-1:0]        blk;
  logic [2:0]           word;
  logic [31:0]          be;
  logic [31:0]          rd_word;
  logic [PW-1:0]        sync_pw, prev_pw, ev, clr;
  logic                 unused_addr;

  // Each 32-byte block is one register group: block 0 = ID/GIE, block 2+b = bank b.
  assign off  = bus.user_addr[ADDR_BITS-1:0];
  assign blk  = off[ADDR_BITS-1:5];
  assign word = off[4:2];
  assign be   = {{8{bus.user_wstrb[3]}}, {8{bus.user_wstrb[2]}},
                 {8{bus.user_wstrb[1]}}, {8{bus.user_wstrb[0]}}};
  assign unused_addr = ^{bus.user_addr[31:ADDR_BITS], bus.user_addr[1:0]};

  always_comb begin
    sync_pw = '0;
    prev_pw = '0;
    sync_pw[GPIO_WIDTH-1:0] = sync_q[SYNC_STAGES-1];
    prev_pw[GPIO_WIDTH-1:0] = prev_q;
    ev = '0;
    // prev is not trustworthy until the chain has fully refilled after reset.
    if (prime_q == PRIME_DONE) begin
      ev = (sync_pw & ~prev_pw & rise_q) | (~sync_pw & prev_pw & fall_q);
    end
  end

  always_comb begin
    rd_word = 32'h0;
    if (blk == '0) begin
      case (word)
        3'd0:    rd_word = {16'h4750, GPIO_W16};
        3'd1:    rd_word = {31'h0, gie_q};
        default: rd_word = 32'h0;
      endcase
    end
    for (int b = 0; b < NB; b++) begin
      if (blk == HB'(b + 2)) begin
        case (word)
          3'd0:    rd_word = sync_pw[b*32 +: 32];
          3'd1:    rd_word = out_q[b*32 +: 32];
          3'd2:    rd_word = dir_q[b*32 +: 32];
          3'd3:    rd_word = mask_q[b*32 +: 32];
          3'd4:    rd_word = rise_q[b*32 +: 32];
          3'd5:    rd_word = fall_q[b*32 +: 32];
          3'd6:    rd_word = stat_q[b*32 +: 32];
          default: rd_word = 32'h0;
        endcase
      end
    end
  end

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    rise_d = rise_q;
    fall_d = fall_q;
    gie_d  = gie_q;
    clr    = '0;
    if (bus.user_wren) begin
      if (blk == '0 && word == 3'd1 && bus.user_wstrb[0]) gie_d = bus.user_wr_data[0];
      for (int b = 0; b < NB; b++) begin
        if (blk == HB'(b + 2)) begin
          case (word)
            3'd1:    out_d[b*32 +: 32]  = merge(out_q[b*32 +: 32], bus.user_wr_data, be);
            3'd2:    dir_d[b*32 +: 32]  = merge(dir_q[b*32 +: 32], bus.user_wr_data, be);
            3'd3:    mask_d[b*32 +: 32] = merge(mask_q[b*32 +: 32], bus.user_wr_data, be);
            3'd4:    rise_d[b*32 +: 32] = merge(rise_q[b*32 +: 32], bus.user_wr_data, be);
            3'd5:    fall_d[b*32 +: 32] = merge(fall_q[b*32 +: 32], bus.user_wr_data, be);
            3'd6:    clr[b*32 +: 32]    = bus.user_wr_data & be;
            default: ;
          endcase
        end
      end
    end
    out_d  = out_d & PMASK;
    dir_d  = dir_d & PMASK;
    mask_d = mask_d & PMASK;
    rise_d = rise_d & PMASK;
    fall_d = fall_d & PMASK;
    // A new event beats a simultaneous W1C so no edge is ever lost.
    stat_d = ((stat_q & ~clr) | ev) & PMASK;
    irq_d  = gie_q & (|(stat_q & mask_q));
    rd_d   = bus.user_rden ? rd_word : rd_q;
    prime_d = (prime_q == PRIME_DONE) ? prime_q : prime_q + CW'(1);
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      out_q   <= '0;
      dir_q   <= '0;
      mask_q  <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      stat_q  <= '0;
      gie_q   <= 1'b0;
      rd_q    <= '0;
      irq_q   <= 1'b0;
      prime_q <= '0;
      prev_q  <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      mask_q  <= mask_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      stat_q  <= stat_d;
      gie_q   <= gie_d;
      rd_q    <= rd_d;
      irq_q   <= irq_d;
      prime_q <= prime_d;
      sync_q[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign bus.user_rd_data = rd_q;
  assign bus.user_irq     = irq_q;
  assign gpio_o = out_q[GPIO_WIDTH-1:0];
  assign gpio_t = ~dir_q[GPIO_WIDTH-1:0];
endmodule

// File: tb/tb_xillybus_lite_gpio_irq.sv
// Bench for xillybus_lite_gpio_irq: directed register/IRQ scenarios plus random traffic vs a register-map model.
module tb_xillybus_lite_gpio_irq;
  localparam int W  = 56;
  localparam int S  = 2;
  localparam int NB = 2;

  logic         bus_clk   = 1'b0;
  logic         bus_rst_n = 1'b0;
  logic [W-1:0] gpio_i    = '0;
  logic [W-1:0] gpio_o, gpio_t;

  xillybus_lite_gpio_irq_if bus ();

  xillybus_lite_gpio_irq #(.GPIO_WIDTH(W), .SYNC_STAGES(S), .ADDR_BITS(8)) dut (
    .bus_clk  (bus_clk),
    .bus_rst_n(bus_rst_n),
    .bus      (bus),
    .gpio_i   (gpio_i),
    .gpio_o   (gpio_o),
    .gpio_t   (gpio_t)
  );

  always #5 bus_clk = ~bus_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Register-map model; pin_hist[j-1] is the pin vector sampled at the j-th edge since reset release.
  bit [31:0] m_out [NB];
  bit [31:0] m_dir [NB];
  bit [31:0] m_mask[NB];
  bit [31:0] m_rise[NB];
  bit [31:0] m_fall[NB];
  bit [31:0] m_stat[NB];
  bit        m_gie, m_irq;
  bit [31:0] m_rd;
  bit [63:0] pin_hist[$];
  int        edges;

  function automatic bit [31:0] lane_bits(input int b);
    bit [31:0] m;
    for (int i = 0; i < 32; i++) m[i] = (b * 32 + i < W);
    return m;
  endfunction

  function automatic bit [31:0] strb_mask(input bit [3:0] s);
    bit [31:0] m;
    m = 32'h0;
    for (int l = 0; l < 4; l++) if (s[l]) m[l*8 +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic bit [31:0] model_read(input bit [31:0] addr, input int k);
    int off, bk, r;
    bit [63:0] pins;
    off = int'(addr[7:0]) & 'hFC;
    if (off == 0) return {16'h4750, 16'(W)};
    if (off == 4) return {31'h0, m_gie};
    if (off < 'h40 || off >= 'h40 + 'h20 * NB) return 32'h0;
    bk = (off - 'h40) / 'h20;
    r  = ((off - 'h40) % 'h20) / 4;
    pins = (k - S >= 1) ? pin_hist[k-S-1] : 64'h0;
    case (r)
      0: return pins[bk*32 +: 32];
      1: return m_out[bk];
      2: return m_dir[bk];
      3: return m_mask[bk];
      4: return m_rise[bk];
      5: return m_fall[bk];
      6: return m_stat[bk];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_out[b] = 0; m_dir[b] = 0; m_mask[b] = 0;
      m_rise[b] = 0; m_fall[b] = 0; m_stat[b] = 0;
    end
    m_gie = 0; m_irq = 0; m_rd = 0;
    pin_hist.delete();
    edges = 0;
  endtask

  task automatic model_edge(input bit wren, input bit rden, input bit [31:0] addr,
                            input bit [3:0] strb, input bit [31:0] wd, input bit [63:0] pin);
    int k, off, bk, r;
    bit [31:0] new_rd, sm, rs, fl;
    bit [31:0] setb[NB];
    bit irq_n;
    bit [63:0] cur, old;
    k = edges + 1;
    new_rd = m_rd;
    if (rden) new_rd = model_read(addr, k);
    irq_n = 0;
    for (int b = 0; b < NB; b++) begin
      setb[b] = 0;
      if ((m_stat[b] & m_mask[b]) != 0 && m_gie) irq_n = 1;
    end
    if (k >= S + 2) begin
      cur = pin_hist[k-S-1];
      old = pin_hist[k-S-2];
      for (int b = 0; b < NB; b++) begin
        rs = cur[b*32 +: 32] & ~old[b*32 +: 32];
        fl = ~cur[b*32 +: 32] & old[b*32 +: 32];
        setb[b] = (rs & m_rise[b]) | (fl & m_fall[b]);
      end
    end
    if (wren) begin
      off = int'(addr[7:0]) & 'hFC;
      sm  = strb_mask(strb);
      if (off == 4 && strb[0]) m_gie = wd[0];
      if (off >= 'h40 && off < 'h40 + 'h20 * NB) begin
        bk = (off - 'h40) / 'h20;
        r  = ((off - 'h40) % 'h20) / 4;
        case (r)
          1: m_out[bk]  = ((m_out[bk]  & ~sm) | (wd & sm)) & lane_bits(bk);
          2: m_dir[bk]  = ((m_dir[bk]  & ~sm) | (wd & sm)) & lane_bits(bk);
          3: m_mask[bk] = ((m_mask[bk] & ~sm) | (wd & sm)) & lane_bits(bk);
          4: m_rise[bk] = ((m_rise[bk] & ~sm) | (wd & sm)) & lane_bits(bk);
          5: m_fall[bk] = ((m_fall[bk] & ~sm) | (wd & sm)) & lane_bits(bk);
          6: m_stat[bk] = m_stat[bk] & ~(wd & sm);
          default: ;
        endcase
      end
    end
    for (int b = 0; b < NB; b++) m_stat[b] = m_stat[b] | setb[b];
    m_rd  = new_rd;
    m_irq = irq_n;
    pin_hist.push_back(pin);
    edges = k;
  endtask

  function automatic bit [W-1:0] exp_o();
    bit [63:0] v;
    for (int b = 0; b < NB; b++) v[b*32 +: 32] = m_out[b];
    return v[W-1:0];
  endfunction

  function automatic bit [W-1:0] exp_t();
    bit [63:0] v;
    for (int b = 0; b < NB; b++) v[b*32 +: 32] = ~m_dir[b];
    return v[W-1:0];
  endfunction

  task automatic tick();
    bit wr, rd, live;
    bit [31:0] a, d;
    bit [3:0] s;
    bit [63:0] p;
    wr = bus.user_wren; rd = bus.user_rden; a = bus.user_addr;
    s = bus.user_wstrb; d = bus.user_wr_data; p = 64'(gpio_i); live = bus_rst_n;
    @(posedge bus_clk);
    if (live) model_edge(wr, rd, a, s, d, p);
    #1;
    check("irq", bus.user_irq, m_irq);
    check("gpio_o", gpio_o, exp_o());
    check("gpio_t", gpio_t, exp_t());
    if (rd && live) check("rd_data", bus.user_rd_data, m_rd);
  endtask

  task automatic bus_idle();
    bus.user_wren = 0; bus.user_rden = 0; bus.user_wstrb = 0;
    bus.user_addr = 0; bus.user_wr_data = 0;
  endtask

  task automatic wr(input bit [31:0] a, input bit [31:0] d, input bit [3:0] s);
    bus.user_addr = a; bus.user_wr_data = d; bus.user_wstrb = s; bus.user_wren = 1;
    tick();
    bus_idle();
  endtask

  task automatic rd(input bit [31:0] a, output bit [31:0] d);
    bus.user_addr = a; bus.user_rden = 1;
    tick();
    d = bus.user_rd_data;
    bus_idle();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic apply_reset();
    bus_rst_n = 0;
    model_reset();
    #1;
    check("rst_irq", bus.user_irq, 0);
    check("rst_rd_data", bus.user_rd_data, 0);
    check("rst_gpio_t", gpio_t, {W{1'b1}});
    idle(2);
    bus_rst_n = 1;
  endtask

  initial begin
    bit [31:0] d, a;
    logic [W-1:0] one;
    int r;
    one = 1;
    bus_idle();
    model_reset();
    idle(3);
    check("reset_gpio_t", gpio_t, {W{1'b1}});
    check("reset_gpio_o", gpio_o, 0);
    check("reset_irq", bus.user_irq, 0);
    check("reset_rd", bus.user_rd_data, 0);
    bus_rst_n = 1;

    rd(32'h0, d);   check("id", d, 32'h4750_0038);
    rd(32'h48, d);  check("dir0_reset", d, 32'h0);
    wr(32'h48, 32'h0000_FFFF, 4'b0011);
    wr(32'h44, 32'hA5A5_A5A5, 4'hF);
    check("gpio_t_lo", gpio_t[31:0], 32'hFFFF_0000);
    check("gpio_o_lo", gpio_o[31:0], 32'hA5A5_A5A5);
    wr(32'h68, 32'hFFFF_FFFF, 4'hF);
    check("gpio_t_hi", gpio_t[55:32], 24'h0);
    rd(32'h68, d);  check("dir1_rb", d, 32'h00FF_FFFF);
    rd(32'h7C, d);  check("bank1_1c", d, 32'h0);

    // Pins high through reset release with RISE armed inside the priming window.
    gpio_i = '1;
    apply_reset();
    wr(32'h50, 32'hFFFF_FFFF, 4'hF);
    wr(32'h70, 32'hFFFF_FFFF, 4'hF);
    idle(10);
    rd(32'h58, d);  check("prime_stat0", d, 32'h0);
    rd(32'h78, d);  check("prime_stat1", d, 32'h0);

    wr(32'h50, 32'h8, 4'hF);
    wr(32'h70, 32'h0, 4'hF);
    wr(32'h4C, 32'h8, 4'hF);
    wr(32'h04, 32'h1, 4'hF);
    gpio_i = '0;
    idle(6);
    wr(32'h58, 32'hFFFF_FFFF, 4'hF);
    wr(32'h78, 32'hFFFF_FFFF, 4'hF);
    idle(2);
    gpio_i[3] = 1'b1;
    idle(3);
    check("irq_edge3", bus.user_irq, 0);
    rd(32'h58, d);
    check("stat_edge3", d, 32'h8);
    check("irq_edge4", bus.user_irq, 1);
    wr(32'h58, 32'h8, 4'b0001);
    check("irq_clr_edge", bus.user_irq, 1);
    tick();
    check("irq_clr_next", bus.user_irq, 0);

    gpio_i[3] = 1'b0; idle(5);
    gpio_i[3] = 1'b1; idle(4);
    check("irq_rearm", bus.user_irq, 1);
    gpio_i[3] = 1'b0; idle(5);
    gpio_i[3] = 1'b1; idle(2);
    wr(32'h58, 32'h8, 4'b0001);
    check("irq_setwins0", bus.user_irq, 1);
    tick();
    check("irq_setwins1", bus.user_irq, 1);
    rd(32'h58, d);  check("stat_setwins", d, 32'h8);
    wr(32'h58, 32'h8, 4'b0001);
    idle(2);
    check("irq_cleared", bus.user_irq, 0);

    wr(32'h74, 32'h100, 4'hF);
    gpio_i[40] = 1'b1; idle(6);
    gpio_i[40] = 1'b0; idle(6);
    rd(32'h78, d);  check("stat1_fall40", d, 32'h100);
    check("irq_masked", bus.user_irq, 0);
    wr(32'h6C, 32'h100, 4'hF);
    tick();
    check("irq_unmask", bus.user_irq, 1);
    apply_reset();
    rd(32'h78, d);  check("stat1_after_rst", d, 32'h0);

    // Random traffic: reads, writes (including unmapped and partial strobes) and pin toggles.
    wr(32'h4C, 32'hFFFF_FFFF, 4'hF);
    wr(32'h6C, 32'hFFFF_FFFF, 4'hF);
    wr(32'h50, $urandom(), 4'hF);
    wr(32'h74, $urandom(), 4'hF);
    wr(32'h04, 32'h1, 4'hF);
    for (int c = 0; c < 2000; c++) begin
      bus_idle();
      r = $urandom_range(0, 9);
      a = ($urandom() & 32'hFFFF_FF00) | ($urandom_range(0, 47) * 4) | $urandom_range(0, 3);
      if (r < 4) begin
        bus.user_wren = 1; bus.user_addr = a;
        bus.user_wr_data = $urandom(); bus.user_wstrb = 4'($urandom_range(0, 15));
      end
      if (r >= 2 && r < 7) begin
        bus.user_rden = 1; bus.user_addr = a;
      end
      if ($urandom_range(0, 2) == 0) gpio_i = gpio_i ^ (one << $urandom_range(0, W - 1));
      if (c == 1000) begin
        bus_idle();
        apply_reset();
        wr(32'h04, 32'h1, 4'hF);
        wr(32'h4C, $urandom(), 4'hF);
        wr(32'h70, $urandom(), 4'hF);
        wr(32'h6C, $urandom(), 4'hF);
      end else begin
        tick();
      end
    end
    bus_idle();
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
